// File: rtl/stream_downsize_if.sv
// Handshake bundle for stream_downsize: one wide input stream and one narrow output stream.
// The slave modport is the converter's view; master is the environment driving it.
interface stream_downsize_if #(
  parameter int T_DATA_WIDTH  = 32,
  parameter int T_DATA_RATIO  = 3,
  parameter int T_WIDTH_RATIO = $clog2(T_DATA_RATIO)
);
  logic [T_DATA_RATIO-1:0][T_DATA_WIDTH-1:0] s_data_i;
  logic [T_WIDTH_RATIO:0]                    s_keep_i;
  logic                                      s_last_i;
  logic                                      s_valid_i;
  logic                                      s_ready_o;
  logic [T_DATA_WIDTH-1:0]                   m_data_o;
  logic                                      m_last_o;
  logic                                      m_valid_o;
  logic                                      m_ready_i;

  modport slave (
    input  s_data_i, s_keep_i, s_last_i, s_valid_i, m_ready_i,
    output s_ready_o, m_data_o, m_last_o, m_valid_o
  );

  modport master (
    output s_data_i, s_keep_i, s_last_i, s_valid_i, m_ready_i,
    input  s_ready_o, m_data_o, m_last_o, m_valid_o
  );
endinterface

// File: rtl/stream_downsize.sv
// Wide-to-narrow stream converter: holds one wide beat and emits its first keep words
// one per cycle, reloading on the cycle the final word leaves so beats stream bubble-free.
module stream_downsize #(
  parameter int T_DATA_WIDTH  = 32,
  parameter int T_DATA_RATIO  = 3,
  parameter int T_WIDTH_RATIO = $clog2(T_DATA_RATIO)
) (
  input logic              clk,
  input logic              rst,
  stream_downsize_if.slave bus
);
  localparam int KW = T_WIDTH_RATIO + 1;
  localparam logic [KW-1:0] RATIO_K = KW'(T_DATA_RATIO);

  logic [T_DATA_RATIO-1:0][T_DATA_WIDTH-1:0] word_buf;
  logic [KW-1:0]            cnt;
  logic [KW-1:0]            keep_clamped;
  logic [KW-1:0]            last_idx;
  logic [T_WIDTH_RATIO-1:0] idx;
  logic                     lst;
  logic                     full;
  logic                     at_last;
  logic                     accept;
  logic                     emit;

  // Clamp at capture so cnt is always 1..RATIO and idx can never run past the buffer.
  always_comb begin
    keep_clamped = bus.s_keep_i;
    if (bus.s_keep_i == '0)
      keep_clamped = KW'(1);
    else if (bus.s_keep_i > RATIO_K)
      keep_clamped = RATIO_K;
  end

  assign last_idx = cnt - KW'(1);
  assign at_last  = ({1'b0, idx} == last_idx);

  // m_ready_i feeds s_ready_o combinationally so a new beat loads as the last word leaves.
  assign bus.s_ready_o = !rst && (!full || (bus.m_ready_i && at_last));
  assign accept        = bus.s_valid_i && bus.s_ready_o;
  assign emit          = full && bus.m_ready_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      word_buf <= '0;
      cnt      <= '0;
      idx      <= '0;
      lst      <= 1'b0;
      full     <= 1'b0;
    end else if (accept) begin
      word_buf <= bus.s_data_i;
      cnt      <= keep_clamped;
      lst      <= bus.s_last_i;
      idx      <= '0;
      full     <= 1'b1;
    end else if (emit) begin
      if (at_last)
        full <= 1'b0;
      else
        idx <= idx + 1'b1;
    end
  end

  assign bus.m_valid_o = full;
  assign bus.m_data_o  = word_buf[idx];
  assign bus.m_last_o  = full && lst && at_last;
endmodule

// File: tb/tb_stream_downsize.sv
// Randomised scoreboard bench for stream_downsize: accepted wide beats are expanded into a
// queue of expected narrow words that an independent monitor pops on every output handshake.
module tb_stream_downsize;
  localparam int W = 32;
  localparam int R = 3;

  typedef struct packed {
    logic [W-1:0] data;
    logic         last;
  } word_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stream_downsize_if #(.T_DATA_WIDTH(W), .T_DATA_RATIO(R)) bus ();

  stream_downsize #(.T_DATA_WIDTH(W), .T_DATA_RATIO(R)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  word_t  exp_q[$];
  int     n_pass = 0;
  int     n_total = 0;
  bit     started = 1'b0;
  bit     stall_prev = 1'b0;
  word_t  stall_word;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Monitor: output presence must match outstanding words; handshakes pop the scoreboard.
  always @(negedge clk) begin
    if (rst || !started) begin
      stall_prev = 1'b0;
    end else begin
      chk("m_valid", W'(bus.m_valid_o), W'(exp_q.size() != 0));
      if (stall_prev && bus.m_valid_o) begin
        chk("stall_data", bus.m_data_o, stall_word.data);
        chk("stall_last", W'(bus.m_last_o), W'(stall_word.last));
      end
      if (bus.m_valid_o && bus.m_ready_i) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", bus.m_data_o, 'x);
        end else begin
          word_t e;
          e = exp_q.pop_front();
          chk("m_data", bus.m_data_o, e.data);
          chk("m_last", W'(bus.m_last_o), W'(e.last));
        end
      end
      stall_prev      = bus.m_valid_o && !bus.m_ready_i;
      stall_word.data = bus.m_data_o;
      stall_word.last = bus.m_last_o;
    end
  end

  // Reference expansion: keep 0 means one word, above R means R words.
  task automatic push_beat(input logic [R-1:0][W-1:0] d, input int keep, input bit last);
    int k;
    word_t e;
    k = (keep == 0) ? 1 : ((keep > R) ? R : keep);
    for (int i = 0; i < k; i++) begin
      e.data = d[i];
      e.last = last && (i == k - 1);
      exp_q.push_back(e);
    end
  endtask

  // One clock of stimulus, entered and left just after a posedge.
  task automatic drive_cycle(input bit v, input logic [R-1:0][W-1:0] d, input int keep,
                             input bit last, input bit mr, output bit acc);
    bus.s_valid_i = v;
    bus.s_data_i  = d;
    bus.s_keep_i  = (R'(keep));
    bus.s_last_i  = last;
    bus.m_ready_i = mr;
    @(negedge clk);
    #1;
    // After the monitor's pop, the buffer can take a beat exactly when nothing remains.
    chk("s_ready", W'(bus.s_ready_o), W'(exp_q.size() == 0));
    acc = v && bus.s_ready_o;
    if (acc) push_beat(d, keep, last);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit mr);
    bit acc;
    drive_cycle(1'b0, '0, 0, 1'b0, mr, acc);
  endtask

  // ready_pct: probability (percent) of m_ready_i high on each cycle while offering the beat.
  task automatic send_beat(input logic [R-1:0][W-1:0] d, input int keep, input bit last,
                           input int ready_pct);
    bit acc;
    int tries;
    acc = 1'b0;
    tries = 0;
    while (!acc && tries < 50) begin
      drive_cycle(1'b1, d, keep, last, ($urandom_range(99) < ready_pct), acc);
      tries++;
    end
    if (!acc) chk("accept_timeout", W'(0), W'(1));
    bus.s_valid_i = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      idle(1'b1);
      guard++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", W'(exp_q.size()), W'(0));
  endtask

  logic [R-1:0][W-1:0] d;

  initial begin
    bus.s_valid_i = 1'b1;
    bus.s_data_i  = '1;
    bus.s_keep_i  = 2'd3;
    bus.s_last_i  = 1'b1;
    bus.m_ready_i = 1'b1;
    rst = 1'b1;

    // Reset held two cycles with a valid beat offered.
    @(posedge clk);
    #1;
    repeat (2) begin
      @(negedge clk);
      chk("rst_s_ready", W'(bus.s_ready_o), W'(0));
      chk("rst_m_valid", W'(bus.m_valid_o), W'(0));
      chk("rst_m_data", bus.m_data_o, W'(0));
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    bus.s_valid_i = 1'b0;
    started = 1'b1;

    // Full beat, consumed at full rate.
    d = {32'hCCCC_000C, 32'hBBBB_000B, 32'hAAAA_000A};
    send_beat(d, 3, 1'b1, 100);
    drain();
    idle(1'b1);

    // Back-to-back beats: second beat must load as the first beat's last word leaves.
    d = {32'd3, 32'd2, 32'd1};
    send_beat(d, 3, 1'b0, 100);
    d = {32'd6, 32'd5, 32'd4};
    send_beat(d, 2, 1'b1, 100);
    drain();

    // Stall on word B for four cycles with a competing beat offered.
    d = {32'hC0, 32'hB0, 32'hA0};
    send_beat(d, 3, 1'b1, 100);
    idle(1'b1);
    begin
      bit acc;
      d = {32'hF3, 32'hF2, 32'hF1};
      repeat (4) drive_cycle(1'b1, d, 3, 1'b0, 1'b0, acc);
      bus.s_valid_i = 1'b0;
    end
    drain();

    // keep boundaries.
    d = {32'h33, 32'h22, 32'h11};
    send_beat(d, 0, 1'b1, 100);
    d = {32'h66, 32'h55, 32'h44};
    send_beat(d, 7, 1'b1, 100);
    drain();

    // Randomised traffic with random backpressure and gaps.
    for (int b = 0; b < 300; b++) begin
      for (int i = 0; i < R; i++) d[i] = $urandom();
      if ($urandom_range(3) == 0) idle($urandom_range(1));
      send_beat(d, int'($urandom_range(7)), $urandom_range(1) == 1, 60);
    end
    drain();

    // Reset after the first word of a beat has left: remaining words are dropped.
    d = {32'hDEAD_000C, 32'hDEAD_000B, 32'hDEAD_000A};
    send_beat(d, 3, 1'b1, 100);
    idle(1'b1);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_mid_m_valid", W'(bus.m_valid_o), W'(0));
    chk("rst_mid_m_last", W'(bus.m_last_o), W'(0));
    chk("rst_mid_s_ready", W'(bus.s_ready_o), W'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) idle(1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
